// File: rtl/rob_commit_ctrl.sv
// In-order reorder buffer with commit sequencing and mispredict flush.
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (global stall when low)
//   issue_valid/issue_rd -> issue_ready, issue_rob_id : allocation handshake
//   new_reg_id/new_ROB_id : rename request to the register file
//   cdb_valid/cdb_rob_id/cdb_val/cdb_mispredict/cdb_target : result broadcast
//   rs1_id/rs2_id -> rs1/rs2_ready, rs1/rs2_val : operand forwarding lookup
//   write_reg_id/write_ROB_id/write_val : registered commit write port
//   clear_flag/redirect_pc : registered flush pulse and restart PC
module rob_commit_ctrl #(
  parameter int unsigned ROB_WIDTH_BIT = 3
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     issue_valid,
  input  logic [4:0]               issue_rd,
  output logic                     issue_ready,
  output logic [ROB_WIDTH_BIT-1:0] issue_rob_id,
  output logic [4:0]               new_reg_id,
  output logic [ROB_WIDTH_BIT-1:0] new_ROB_id,
  input  logic                     cdb_valid,
  input  logic [ROB_WIDTH_BIT-1:0] cdb_rob_id,
  input  logic [31:0]              cdb_val,
  input  logic                     cdb_mispredict,
  input  logic [31:0]              cdb_target,
  input  logic [ROB_WIDTH_BIT-1:0] rs1_id,
  input  logic [ROB_WIDTH_BIT-1:0] rs2_id,
  output logic                     rs1_ready,
  output logic                     rs2_ready,
  output logic [31:0]              rs1_val,
  output logic [31:0]              rs2_val,
  output logic [4:0]               write_reg_id,
  output logic [ROB_WIDTH_BIT-1:0] write_ROB_id,
  output logic [31:0]              write_val,
  output logic                     clear_flag,
  output logic [31:0]              redirect_pc
);

  localparam int unsigned W     = ROB_WIDTH_BIT;
  localparam int unsigned DEPTH = 1 << W;
  localparam int unsigned CW    = W + 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  typedef struct packed {
    logic        busy;
    logic        ready;
    logic        mis;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [31:0] target;
  } rob_entry_t;

  state_t     state, state_next;
  rob_entry_t entries [DEPTH];
  logic [W-1:0]  head, tail;
  logic [CW-1:0] count, count_next;

  rob_entry_t head_e;
  logic       accept;
  logic       commit;
  logic       cdb_hit;

  // Issue handshake, commit decision and FSM next state
  always_comb begin
    state_next  = state;
    head_e      = entries[head];
    issue_ready = 1'b0;
    accept      = 1'b0;
    commit      = 1'b0;
    cdb_hit     = 1'b0;
    new_reg_id  = 5'd0;
    count_next  = count;

    // Full check uses count before any same-cycle commit (no pass-through)
    issue_ready = rdy_in && (state == ST_RUN) && (count != CW'(DEPTH));
    accept      = issue_valid && issue_ready;
    new_reg_id  = accept ? issue_rd : 5'd0;
    commit      = rdy_in && (state == ST_RUN) && head_e.busy && head_e.ready;
    cdb_hit     = rdy_in && (state == ST_RUN) && cdb_valid && entries[cdb_rob_id].busy;
    count_next  = count + CW'(accept) - CW'(commit);

    case (state)
      ST_RUN:   if (commit && head_e.mis) state_next = ST_DRAIN;
      ST_DRAIN: state_next = ST_CLEAR;
      ST_CLEAR: state_next = ST_RUN;
      default:  state_next = ST_RUN;
    endcase
  end

  assign issue_rob_id = tail;
  assign new_ROB_id   = tail;

  // Operand lookup: a same-cycle CDB broadcast wins over the stored entry
  always_comb begin
    rs1_ready = (cdb_valid && (cdb_rob_id == rs1_id)) ||
                (entries[rs1_id].busy && entries[rs1_id].ready);
    rs2_ready = (cdb_valid && (cdb_rob_id == rs2_id)) ||
                (entries[rs2_id].busy && entries[rs2_id].ready);
    rs1_val   = (cdb_valid && (cdb_rob_id == rs1_id)) ? cdb_val : entries[rs1_id].val;
    rs2_val   = (cdb_valid && (cdb_rob_id == rs2_id)) ? cdb_val : entries[rs2_id].val;
  end

  // FSM state register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= ST_RUN;
    end else if (rdy_in) begin
      state <= state_next;
    end
  end

  // Entry storage, pointers and registered commit/flush outputs
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < int'(DEPTH); i++) entries[i] <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      write_reg_id <= 5'd0;
      write_ROB_id <= '0;
      write_val    <= 32'd0;
      clear_flag   <= 1'b0;
      redirect_pc  <= 32'd0;
    end else if (rdy_in) begin
      clear_flag <= (state_next == ST_CLEAR);
      if (state == ST_CLEAR) begin
        for (int i = 0; i < int'(DEPTH); i++) entries[i].busy <= 1'b0;
        head         <= '0;
        tail         <= '0;
        count        <= '0;
        write_reg_id <= 5'd0;
      end else begin
        if (cdb_hit) begin
          entries[cdb_rob_id].ready  <= 1'b1;
          entries[cdb_rob_id].val    <= cdb_val;
          entries[cdb_rob_id].mis    <= cdb_mispredict;
          entries[cdb_rob_id].target <= cdb_target;
        end
        if (commit) begin
          write_reg_id        <= head_e.rd;
          write_ROB_id        <= head;
          write_val           <= head_e.val;
          entries[head].busy  <= 1'b0;
          head                <= head + W'(1);
          if (head_e.mis) redirect_pc <= head_e.target;
        end else begin
          write_reg_id <= 5'd0;
        end
        // tail is never busy while accepting, so this cannot collide with the CDB write
        if (accept) begin
          entries[tail].busy  <= 1'b1;
          entries[tail].ready <= 1'b0;
          entries[tail].mis   <= 1'b0;
          entries[tail].rd    <= issue_rd;
          tail                <= tail + W'(1);
        end
        count <= count_next;
      end
    end
  end

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed bench for rob_commit_ctrl: vector table plus hand-written corner sequences.
module tb_rob_commit_ctrl;

  localparam bit Y = 1'b1;
  localparam bit N = 1'b0;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, issue_valid, cdb_valid, cdb_mispredict;
  logic [4:0]  issue_rd;
  logic [2:0]  cdb_rob_id, rs1_id, rs2_id;
  logic [31:0] cdb_val, cdb_target;
  logic        issue_ready, rs1_ready, rs2_ready, clear_flag;
  logic [2:0]  issue_rob_id, new_ROB_id, write_ROB_id;
  logic [4:0]  new_reg_id, write_reg_id;
  logic [31:0] rs1_val, rs2_val, write_val, redirect_pc;

  int checks = 0;
  int errors = 0;

  rob_commit_ctrl #(.ROB_WIDTH_BIT(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .issue_rob_id(issue_rob_id), .new_reg_id(new_reg_id), .new_ROB_id(new_ROB_id),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_val(cdb_val),
    .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
    .rs1_val(rs1_val), .rs2_val(rs2_val),
    .write_reg_id(write_reg_id), .write_ROB_id(write_ROB_id), .write_val(write_val),
    .clear_flag(clear_flag), .redirect_pc(redirect_pc)
  );

  always #5 clk_in = ~clk_in;

  // One cycle of stimulus with expected combinational and post-edge outputs
  typedef struct {
    bit rst; bit rdy; bit iv; logic [4:0] ird;
    bit cv; logic [2:0] cid; logic [31:0] cval; bit cmis; logic [31:0] ctgt;
    logic [2:0] rs;
    bit chk_c; bit e_ir; logic [4:0] e_nreg; logic [2:0] e_nrob;
    bit chk_rs; bit e_rsr; logic [31:0] e_rsv;
    bit chk_w; logic [4:0] e_wreg; logic [2:0] e_wrob; logic [31:0] e_wval;
    bit e_clr; logic [31:0] e_pc;
  } vec_t;

  localparam int NV = 28;
  vec_t vt [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input bit rst, input bit rdy, input bit iv, input logic [4:0] ird,
                       input bit cv, input logic [2:0] cid, input logic [31:0] cval,
                       input bit cmis, input logic [31:0] ctgt);
    rst_in = rst; rdy_in = rdy; issue_valid = iv; issue_rd = ird;
    cdb_valid = cv; cdb_rob_id = cid; cdb_val = cval;
    cdb_mispredict = cmis; cdb_target = ctgt;
  endtask

  task automatic apply(input vec_t v, input int idx);
    drive(v.rst, v.rdy, v.iv, v.ird, v.cv, v.cid, v.cval, v.cmis, v.ctgt);
    rs1_id = v.rs; rs2_id = v.rs;
    #1;
    if (v.chk_c) begin
      chk($sformatf("v%0d issue_ready", idx), 32'(issue_ready), 32'(v.e_ir));
      chk($sformatf("v%0d new_reg_id", idx), 32'(new_reg_id), 32'(v.e_nreg));
      chk($sformatf("v%0d new_ROB_id", idx), 32'(new_ROB_id), 32'(v.e_nrob));
      chk($sformatf("v%0d issue_rob_id", idx), 32'(issue_rob_id), 32'(v.e_nrob));
    end
    if (v.chk_rs) begin
      chk($sformatf("v%0d rs1_ready", idx), 32'(rs1_ready), 32'(v.e_rsr));
      chk($sformatf("v%0d rs2_ready", idx), 32'(rs2_ready), 32'(v.e_rsr));
      if (v.e_rsr) begin
        chk($sformatf("v%0d rs1_val", idx), rs1_val, v.e_rsv);
        chk($sformatf("v%0d rs2_val", idx), rs2_val, v.e_rsv);
      end
    end
    @(posedge clk_in);
    #1;
    if (v.chk_w) begin
      chk($sformatf("v%0d write_reg_id", idx), 32'(write_reg_id), 32'(v.e_wreg));
      chk($sformatf("v%0d write_ROB_id", idx), 32'(write_ROB_id), 32'(v.e_wrob));
      chk($sformatf("v%0d write_val", idx), write_val, v.e_wval);
    end
    chk($sformatf("v%0d clear_flag", idx), 32'(clear_flag), 32'(v.e_clr));
    chk($sformatf("v%0d redirect_pc", idx), redirect_pc, v.e_pc);
  endtask

  initial begin
    //        rst rdy iv ird    cv cid   cval          cmis ctgt        rs    chk_c ir nreg nrob  chk_rs rsr rsv       chk_w wreg wrob wval        clr pc
    // Basic issue -> CDB -> commit, forwarding lookup
    vt[0]  = '{Y,Y, N,5'd0, N,3'd0,32'h0,    N,32'h0,   3'd0, N,N,5'd0,3'd0, N,N,32'h0,    Y,5'd0,3'd0,32'h0,    N,32'h0};
    vt[1]  = '{N,Y, Y,5'd5, N,3'd0,32'h0,    N,32'h0,   3'd0, Y,Y,5'd5,3'd0, N,N,32'h0,    Y,5'd0,3'd0,32'h0,    N,32'h0};
    vt[2]  = '{N,Y, N,5'd0, Y,3'd0,32'h1234, N,32'h0,   3'd0, Y,Y,5'd0,3'd1, Y,Y,32'h1234, Y,5'd0,3'd0,32'h0,    N,32'h0};
    vt[3]  = '{N,Y, N,5'd0, N,3'd0,32'h0,    N,32'h0,   3'd0, Y,Y,5'd0,3'd1, Y,Y,32'h1234, Y,5'd5,3'd0,32'h1234, N,32'h0};
    vt[4]  = '{N,Y, N,5'd0, N,3'd0,32'h0,    N,32'h0,   3'd0, Y,Y,5'd0,3'd1, Y,N,32'h0,    Y,5'd0,3'd0,32'h1234, N,32'h0};
    // Out-of-order completion, in-order commit
    vt[5]  = '{N,Y, Y,5'd1, N,3'd0,32'h0,    N,32'h0,   3'd0, Y,Y,5'd1,3'd1, N,N,32'h0,    Y,5'd0,3'd0,32'h1234, N,32'h0};
    vt[6]  = '{N,Y, Y,5'd2, N,3'd0,32'h0,    N,32'h0,   3'd0, Y,Y,5'd2,3'd2, N,N,32'h0,    Y,5'd0,3'd0,32'h1234, N,32'h0};
    vt[7]  = '{N,Y, Y,5'd3, N,3'd0,32'h0,    N,32'h0,   3'd0, Y,Y,5'd3,3'd3, N,N,32'h0,    Y,5'd0,3'd0,32'h1234, N,32'h0};
    vt[8]  = '{N,Y, N,5'd0, Y,3'd2,32'h22,   N,32'h0,   3'd3, Y,Y,5'd0,3'd4, Y,N,32'h0,    Y,5'd0,3'd0,32'h1234, N,32'h0};
    vt[9]  = '{N,Y, N,5'd0, Y,3'd3,32'h7,    N,32'h0,   3'd3, Y,Y,5'd0,3'd4, Y,Y,32'h7,    Y,5'd0,3'd0,32'h1234, N,32'h0};
    vt[10] = '{N,Y, N,5'd0, N,3'd0,32'h0,    N,32'h0,   3'd3, Y,Y,5'd0,3'd4, Y,Y,32'h7,    Y,5'd0,3'd0,32'h1234, N,32'h0};
    vt[11] = '{N,Y, N,5'd0, Y,3'd1,32'h11,   N,32'h0,   3'd0, Y,Y,5'd0,3'd4, N,N,32'h0,    Y,5'd0,3'd0,32'h1234, N,32'h0};
    vt[12] = '{N,Y, N,5'd0, N,3'd0,32'h0,    N,32'h0,   3'd0, N,N,5'd0,3'd0, N,N,32'h0,    Y,5'd1,3'd1,32'h11,   N,32'h0};
    vt[13] = '{N,Y, N,5'd0, N,3'd0,32'h0,    N,32'h0,   3'd0, N,N,5'd0,3'd0, N,N,32'h0,    Y,5'd2,3'd2,32'h22,   N,32'h0};
    vt[14] = '{N,Y, N,5'd0, N,3'd0,32'h0,    N,32'h0,   3'd0, N,N,5'd0,3'd0, N,N,32'h0,    Y,5'd3,3'd3,32'h7,    N,32'h0};
    vt[15] = '{N,Y, N,5'd0, N,3'd0,32'h0,    N,32'h0,   3'd0, N,N,5'd0,3'd0, N,N,32'h0,    Y,5'd0,3'd3,32'h7,    N,32'h0};
    // Reset mid-run, then mispredicted branch at id1
    vt[16] = '{Y,Y, N,5'd0, N,3'd0,32'h0,    N,32'h0,   3'd0, N,N,5'd0,3'd0, N,N,32'h0,    Y,5'd0,3'd0,32'h0,    N,32'h0};
    vt[17] = '{N,Y, Y,5'd4, N,3'd0,32'h0,    N,32'h0,   3'd0, Y,Y,5'd4,3'd0, N,N,32'h0,    Y,5'd0,3'd0,32'h0,    N,32'h0};
    vt[18] = '{N,Y, Y,5'd1, N,3'd0,32'h0,    N,32'h0,   3'd0, Y,Y,5'd1,3'd1, N,N,32'h0,    Y,5'd0,3'd0,32'h0,    N,32'h0};
    vt[19] = '{N,Y, Y,5'd6, Y,3'd1,32'h55,   Y,32'h100, 3'd0, Y,Y,5'd6,3'd2, N,N,32'h0,    Y,5'd0,3'd0,32'h0,    N,32'h0};
    vt[20] = '{N,Y, N,5'd0, Y,3'd0,32'h40,   N,32'h0,   3'd0, Y,Y,5'd0,3'd3, N,N,32'h0,    Y,5'd0,3'd0,32'h0,    N,32'h0};
    vt[21] = '{N,Y, N,5'd0, N,3'd0,32'h0,    N,32'h0,   3'd0, Y,Y,5'd0,3'd3, N,N,32'h0,    Y,5'd4,3'd0,32'h40,   N,32'h0};
    vt[22] = '{N,Y, Y,5'd8, N,3'd0,32'h0,    N,32'h0,   3'd0, Y,Y,5'd8,3'd3, N,N,32'h0,    Y,5'd1,3'd1,32'h55,   N,32'h100};
    vt[23] = '{N,Y, Y,5'd2, Y,3'd2,32'h99,   N,32'h0,   3'd0, Y,N,5'd0,3'd4, N,N,32'h0,    N,5'd0,3'd0,32'h0,    Y,32'h100};
    vt[24] = '{N,Y, Y,5'd2, N,3'd0,32'h0,    N,32'h0,   3'd0, Y,N,5'd0,3'd4, N,N,32'h0,    Y,5'd0,3'd1,32'h55,   N,32'h100};
    vt[25] = '{N,Y, Y,5'd3, N,3'd0,32'h0,    N,32'h0,   3'd2, Y,Y,5'd3,3'd0, Y,N,32'h0,    Y,5'd0,3'd1,32'h55,   N,32'h100};
    vt[26] = '{N,Y, N,5'd0, Y,3'd0,32'h77,   N,32'h0,   3'd0, Y,Y,5'd0,3'd1, N,N,32'h0,    Y,5'd0,3'd1,32'h55,   N,32'h100};
    vt[27] = '{N,Y, N,5'd0, N,3'd0,32'h0,    N,32'h0,   3'd0, Y,Y,5'd0,3'd1, N,N,32'h0,    Y,5'd3,3'd0,32'h77,   N,32'h100};

    drive(Y, Y, N, 5'd0, N, 3'd0, 32'h0, N, 32'h0);
    rs1_id = 3'd0; rs2_id = 3'd0;
    cyc();
    for (int i = 0; i < NV; i++) apply(vt[i], i);

    // Fill all 8 entries, then check full and tail wrap after one commit
    drive(Y, Y, N, 5'd0, N, 3'd0, 32'h0, N, 32'h0);
    cyc();
    for (int i = 0; i < 8; i++) begin
      drive(N, Y, Y, 5'(i + 10), N, 3'd0, 32'h0, N, 32'h0);
      #1;
      chk($sformatf("fill%0d issue_ready", i), 32'(issue_ready), 32'd1);
      chk($sformatf("fill%0d new_ROB_id", i), 32'(new_ROB_id), 32'(i));
      cyc();
    end
    drive(N, Y, Y, 5'd20, Y, 3'd0, 32'hA0, N, 32'h0);
    #1;
    chk("full issue_ready", 32'(issue_ready), 32'd0);
    chk("full new_reg_id", 32'(new_reg_id), 32'd0);
    cyc();
    drive(N, Y, Y, 5'd20, N, 3'd0, 32'h0, N, 32'h0);
    #1;
    chk("full during commit issue_ready", 32'(issue_ready), 32'd0);
    cyc();
    chk("wrap commit write_reg_id", 32'(write_reg_id), 32'd10);
    chk("wrap commit write_ROB_id", 32'(write_ROB_id), 32'd0);
    chk("wrap commit write_val", write_val, 32'hA0);
    chk("wrap issue_ready", 32'(issue_ready), 32'd1);
    chk("wrap new_reg_id", 32'(new_reg_id), 32'd20);
    chk("wrap new_ROB_id", 32'(new_ROB_id), 32'd0);
    cyc();
    drive(N, Y, N, 5'd0, N, 3'd0, 32'h0, N, 32'h0);
    #1;
    chk("refull issue_ready", 32'(issue_ready), 32'd0);

    // Stall with rdy_in low between two commits
    drive(N, Y, N, 5'd0, Y, 3'd1, 32'hB1, N, 32'h0);
    cyc();
    drive(N, Y, N, 5'd0, Y, 3'd2, 32'hB2, N, 32'h0);
    cyc();
    chk("pre-stall write_reg_id", 32'(write_reg_id), 32'd11);
    for (int i = 0; i < 3; i++) begin
      drive(N, N, Y, 5'd9, Y, 3'd3, 32'hB3, N, 32'h0);
      #1;
      chk($sformatf("stall%0d issue_ready", i), 32'(issue_ready), 32'd0);
      chk($sformatf("stall%0d new_reg_id", i), 32'(new_reg_id), 32'd0);
      cyc();
      chk($sformatf("stall%0d write_reg_id", i), 32'(write_reg_id), 32'd11);
      chk($sformatf("stall%0d write_ROB_id", i), 32'(write_ROB_id), 32'd1);
      chk($sformatf("stall%0d write_val", i), write_val, 32'hB1);
    end
    drive(N, Y, N, 5'd0, N, 3'd0, 32'h0, N, 32'h0);
    cyc();
    chk("post-stall write_reg_id", 32'(write_reg_id), 32'd12);
    chk("post-stall write_ROB_id", 32'(write_ROB_id), 32'd2);
    chk("post-stall write_val", write_val, 32'hB2);
    cyc();
    chk("stall cdb ignored write_reg_id", 32'(write_reg_id), 32'd0);

    // Reset asserted while the flush pulse is active
    drive(Y, Y, N, 5'd0, N, 3'd0, 32'h0, N, 32'h0);
    cyc();
    drive(N, Y, Y, 5'd1, N, 3'd0, 32'h0, N, 32'h0);
    cyc();
    drive(N, Y, N, 5'd0, Y, 3'd0, 32'h5, Y, 32'h200);
    cyc();
    drive(N, Y, N, 5'd0, N, 3'd0, 32'h0, N, 32'h0);
    cyc();
    chk("br write_reg_id", 32'(write_reg_id), 32'd1);
    chk("br redirect_pc", redirect_pc, 32'h200);
    cyc();
    chk("clear clear_flag", 32'(clear_flag), 32'd1);
    drive(Y, Y, N, 5'd0, N, 3'd0, 32'h0, N, 32'h0);
    cyc();
    chk("rst clear_flag", 32'(clear_flag), 32'd0);
    chk("rst redirect_pc", redirect_pc, 32'h0);
    chk("rst write_reg_id", 32'(write_reg_id), 32'd0);
    chk("rst write_ROB_id", 32'(write_ROB_id), 32'd0);
    chk("rst write_val", write_val, 32'h0);
    drive(N, Y, N, 5'd0, N, 3'd0, 32'h0, N, 32'h0);
    #1;
    chk("rst issue_ready", 32'(issue_ready), 32'd1);
    chk("rst issue_rob_id", 32'(issue_rob_id), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
